axis_rgb_pixel_out: RTL and testbench

Converts the VDMA MM2S AXI4-Stream of packed RGB words back into the raster pixel stream (`valid`, `red`, `green`, `blue`) that the camera-side logic and pixel checkers consume. It is the read-back end of the frame-buffer path: the camera pixel stream is written to memory, and this block replays it with programmable blanking. A small FIFO decouples AXI back-pressure from the fixed-rate raster timing.

---
 rtl/axis_rgb_pkg.sv | 34 +++
 rtl/rgb_sync_fifo.sv | 57 +++++
 rtl/axis_rgb_pixel_out.sv | 219 +++++++++++++++++++++
 tb/tb_axis_rgb_pixel_out.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_rgb_pkg.sv
// Shared types and constants for the AXI4-Stream to raster pixel converter.
// With AXIS_RGB_SYNC_CHECK_EN, FIFO entries also carry the SOF/EOL markers.
package axis_rgb_pkg;

  localparam int unsigned RGB_W     = 8;
  localparam int unsigned RED_MSB   = 23;
  localparam int unsigned RED_LSB   = 16;
  localparam int unsigned GREEN_MSB = 15;
  localparam int unsigned GREEN_LSB = 8;
  localparam int unsigned BLUE_MSB  = 7;
  localparam int unsigned BLUE_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VBLANK
  } rgb_out_state_e;

  typedef struct packed {
`ifdef AXIS_RGB_SYNC_CHECK_EN
    logic             tuser;
    logic             tlast;
`endif
    logic [RGB_W-1:0] red;
    logic [RGB_W-1:0] green;
    logic [RGB_W-1:0] blue;
  } rgb_entry_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rgb_sync_fifo.sv
// Single-clock FIFO with registered full/empty/count and first-word-fall-through read.
// full_nxt exposes next-cycle fullness so the stream ready can be a plain register.
module rgb_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   full_nxt,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [AW:0]      count_nxt;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    full_nxt  = (count_nxt == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= full_nxt;
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/axis_rgb_pixel_out.sv
// Replays a VDMA MM2S RGB stream as a raster pixel stream with programmable blanking.
// Define AXIS_RGB_SYNC_CHECK_EN to check SOF/EOL markers and resynchronise on errors.
module axis_rgb_pixel_out
  import axis_rgb_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned HBLANK     = 16,
  parameter int unsigned VBLANK     = 64,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PREFILL    = 8
) (
  input  logic             ACLK,
  input  logic             reset,
  input  logic             s_axis_mm2s_tvalid,
  output logic             s_axis_mm2s_tready,
  input  logic [31:0]      s_axis_mm2s_tdata,
  input  logic             s_axis_mm2s_tuser,
  input  logic             s_axis_mm2s_tlast,
  input  logic             enable,
  output logic             valid,
  output logic [RGB_W-1:0] red,
  output logic [RGB_W-1:0] green,
  output logic [RGB_W-1:0] blue,
  output logic             sof,
  output logic             eol,
  output logic             frame_done,
  output logic             underrun,
  output logic             sync_err
);

  localparam int unsigned ENTRY_W = $bits(rgb_entry_t);
  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned XW      = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned YW      = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned BMAX    = max_u(HBLANK, VBLANK);
  localparam int unsigned BW      = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [XW-1:0] X_LAST    = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(IMG_HEIGHT - 1);
  localparam logic [BW-1:0] HB_LAST   = BW'(HBLANK - 1);
  localparam logic [BW-1:0] VB_LAST   = BW'(VBLANK - 1);
  localparam logic [CW-1:0] PREFILL_C = CW'(PREFILL);

  rgb_out_state_e     state;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [BW-1:0]      bcnt;
  logic               done_pend;

  rgb_entry_t         push_entry;
  rgb_entry_t         head;
  logic [ENTRY_W-1:0] pop_data;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               full_nxt;
  logic               empty;
  logic [CW-1:0]      count;

  logic               first_px;
  logic               last_x;
  logic               head_sof;
  logic               mismatch;
  logic               start;
  logic               unused_bits;

  assign push = s_axis_mm2s_tvalid && s_axis_mm2s_tready;
  assign head = pop_data;

  always_comb begin
    push_entry       = '0;
    push_entry.red   = s_axis_mm2s_tdata[RED_MSB:RED_LSB];
    push_entry.green = s_axis_mm2s_tdata[GREEN_MSB:GREEN_LSB];
    push_entry.blue  = s_axis_mm2s_tdata[BLUE_MSB:BLUE_LSB];
`ifdef AXIS_RGB_SYNC_CHECK_EN
    push_entry.tuser = s_axis_mm2s_tuser;
    push_entry.tlast = s_axis_mm2s_tlast;
`endif
  end

  rgb_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (ACLK),
    .rst_n     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .full_nxt  (full_nxt),
    .empty     (empty),
    .count     (count)
  );

  assign first_px = (x == '0) && (y == '0);
  assign last_x   = (x == X_LAST);

`ifdef AXIS_RGB_SYNC_CHECK_EN
  assign head_sof    = head.tuser;
  assign mismatch    = !empty && ((head.tuser != first_px) || (head.tlast != last_x));
  assign unused_bits = ^{s_axis_mm2s_tdata[31:24], fifo_full};
`else
  assign head_sof    = 1'b1;
  assign mismatch    = 1'b0;
  assign sync_err    = 1'b0;
  assign unused_bits = ^{s_axis_mm2s_tdata[31:24], s_axis_mm2s_tuser, s_axis_mm2s_tlast, fifo_full};
`endif

  // In IDLE a head without SOF is dropped (only possible with the sync check built in).
  assign start = enable && (count >= PREFILL_C) && head_sof;

  always_comb begin
    pop = 1'b0;
    unique case (state)
      ST_ACTIVE: pop = !empty;
      ST_IDLE:   pop = !empty && !head_sof;
      default:   pop = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK or negedge reset) begin
    if (!reset) begin
      state              <= ST_IDLE;
      x                  <= '0;
      y                  <= '0;
      bcnt               <= '0;
      done_pend          <= 1'b0;
      s_axis_mm2s_tready <= 1'b0;
      valid              <= 1'b0;
      red                <= '0;
      green              <= '0;
      blue               <= '0;
      sof                <= 1'b0;
      eol                <= 1'b0;
      frame_done         <= 1'b0;
      underrun           <= 1'b0;
`ifdef AXIS_RGB_SYNC_CHECK_EN
      sync_err           <= 1'b0;
`endif
    end else begin
      s_axis_mm2s_tready <= !full_nxt;
      valid              <= 1'b0;
      red                <= '0;
      green              <= '0;
      blue               <= '0;
      sof                <= 1'b0;
      eol                <= 1'b0;
      done_pend          <= 1'b0;
      frame_done         <= done_pend;

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ACTIVE;
            x     <= '0;
            y     <= '0;
          end
        end
        ST_ACTIVE: begin
          if (mismatch) begin
            state <= ST_IDLE;
`ifdef AXIS_RGB_SYNC_CHECK_EN
            sync_err <= 1'b1;
`endif
          end else begin
            valid <= 1'b1;
            sof   <= first_px;
            eol   <= last_x;
            if (empty) begin
              underrun <= 1'b1;
            end else begin
              red   <= head.red;
              green <= head.green;
              blue  <= head.blue;
            end
            if (last_x) begin
              x <= '0;
              if (y != Y_LAST) begin
                if (HBLANK == 0) begin
                  y <= y + 1'b1;
                end else begin
                  state <= ST_HBLANK;
                  bcnt  <= '0;
                end
              end else begin
                done_pend <= 1'b1;
                if (VBLANK == 0) begin
                  state <= ST_IDLE;
                end else begin
                  state <= ST_VBLANK;
                  bcnt  <= '0;
                end
              end
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        ST_HBLANK: begin
          if (bcnt == HB_LAST) begin
            state <= ST_ACTIVE;
            y     <= y + 1'b1;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        ST_VBLANK: begin
          if (bcnt == VB_LAST) state <= ST_IDLE;
          else                 bcnt  <= bcnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_rgb_pixel_out.sv
// Directed bench for axis_rgb_pixel_out on a 4x2 raster with a 4-entry FIFO.
// Sync-check scenarios run only when AXIS_RGB_SYNC_CHECK_EN is defined.
module tb_axis_rgb_pixel_out;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned HB = 2;
  localparam int unsigned VB = 3;
  localparam int unsigned PF = 2;

  logic        ACLK = 1'b0;
  logic        reset = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [31:0] tdata = '0;
  logic        tuser = 1'b0;
  logic        tlast = 1'b0;
  logic        enable = 1'b0;
  logic        valid;
  logic [7:0]  red, green, blue;
  logic        sof, eol, frame_done, underrun, sync_err;

  axis_rgb_pixel_out #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .HBLANK     (HB),
    .VBLANK     (VB),
    .FIFO_DEPTH (4),
    .PREFILL    (PF)
  ) dut (
    .ACLK               (ACLK),
    .reset              (reset),
    .s_axis_mm2s_tvalid (tvalid),
    .s_axis_mm2s_tready (tready),
    .s_axis_mm2s_tdata  (tdata),
    .s_axis_mm2s_tuser  (tuser),
    .s_axis_mm2s_tlast  (tlast),
    .enable             (enable),
    .valid              (valid),
    .red                (red),
    .green              (green),
    .blue               (blue),
    .sof                (sof),
    .eol                (eol),
    .frame_done         (frame_done),
    .underrun           (underrun),
    .sync_err           (sync_err)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [23:0] rgb;
    logic        sof;
    logic        eol;
    logic        und;
    int          c;
  } pix_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   last_acc = 0;
  int   acc_cyc [16];
  pix_t pix_q [$];
  int   fd_q [$];

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(negedge ACLK) begin : monitor
    pix_t p;
    if (reset) begin
      if (valid) begin
        p.rgb = {red, green, blue};
        p.sof = sof;
        p.eol = eol;
        p.und = underrun;
        p.c   = cyc;
        pix_q.push_back(p);
      end
      if (frame_done) fd_q.push_back(cyc);
    end
  end

  function automatic logic [31:0] beat(input int f, input int i);
    return {8'hA5, 8'(f * 16 + i), 8'(i * 5 + 48), 8'(240 - i)};
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic u, input logic l);
    int  guard = 0;
    bit  done = 1'b0;
    tdata  = d;
    tuser  = u;
    tlast  = l;
    tvalid = 1'b1;
    while (!done && guard < 400) begin
      done = tready;
      tick();
      guard++;
    end
    if (done) begin
      acc_cnt++;
      last_acc = cyc;
    end else begin
      checks++;
      failures++;
      $display("FAIL send_timeout beat=%h not accepted within 400 cycles", d);
    end
    tvalid = 1'b0;
  endtask

  task automatic send_frame(input int f, input int n);
    for (int i = 0; i < n; i++) begin
      send_beat(beat(f, i), (i == 0), ((i % W) == W - 1));
      acc_cyc[i] = last_acc;
    end
  endtask

  task automatic wait_done();
    int g = 0;
    while (fd_q.size() == 0 && g < 300) begin
      tick();
      g++;
    end
    checks++;
    if (fd_q.size() == 0) begin
      failures++;
      $display("FAIL frame_done_timeout got=none required=pulse within 300 cycles");
    end
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    enable = 1'b0;
    tvalid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    pix_q.delete();
    fd_q.delete();
    acc_cnt = 0;
  endtask

  task automatic check_frame(input string tag, input int f, input int base);
    checks++;
    if (pix_q.size() < base + 8) begin
      failures++;
      $display("FAIL %s_pixel_count got=%0d required=%0d", tag, pix_q.size(), base + 8);
    end else begin
      for (int i = 0; i < 8; i++) begin
        logic [31:0] b;
        b = beat(f, i);
        checks++;
        if (pix_q[base+i].rgb !== b[23:0] || pix_q[base+i].sof !== (i == 0)
            || pix_q[base+i].eol !== ((i % W) == W - 1)) begin
          failures++;
          $display("FAIL %s_pixel[%0d] got rgb=%h sof=%b eol=%b required rgb=%h sof=%b eol=%b",
                   tag, i, pix_q[base+i].rgb, pix_q[base+i].sof, pix_q[base+i].eol,
                   b[23:0], (i == 0), ((i % W) == W - 1));
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({tready, valid, red, green, blue, sof, eol, frame_done, underrun, sync_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got tready=%b valid=%b rgb=%h%h%h flags=%b%b%b%b%b required all 0",
               tready, valid, red, green, blue, sof, eol, frame_done, underrun, sync_err);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (tready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_tready got=%b required=0", tready);
    end
    tick();
    checks++;
    if (tready !== 1'b1) begin
      failures++;
      $display("FAIL tready_after_reset got=%b required=1", tready);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    enable = 1'b1;
    send_frame(1, 8);
    wait_done();
    repeat (8) tick();
    check_frame("nominal", 1, 0);
    if (pix_q.size() == 8) begin
      checks++;
      if (pix_q[0].c !== acc_cyc[PF-1] + 2) begin
        failures++;
        $display("FAIL nominal_latency got=%0d required=2", pix_q[0].c - acc_cyc[PF-1]);
      end
      for (int i = 1; i < 8; i++) begin
        int gap;
        gap = (i == 4) ? HB + 1 : 1;
        checks++;
        if (pix_q[i].c - pix_q[i-1].c !== gap) begin
          failures++;
          $display("FAIL nominal_spacing[%0d] got=%0d required=%0d", i, pix_q[i].c - pix_q[i-1].c, gap);
        end
      end
      checks++;
      if (fd_q.size() != 1 || fd_q[0] !== pix_q[7].c + 1) begin
        failures++;
        $display("FAIL nominal_frame_done got count=%0d required single pulse 1 cycle after pixel 7",
                 fd_q.size());
      end
    end
    checks++;
    if (underrun !== 1'b0 || sync_err !== 1'b0) begin
      failures++;
      $display("FAIL nominal_flags got underrun=%b sync_err=%b required 0 0", underrun, sync_err);
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    fork
      send_frame(2, 8);
      begin
        repeat (12) tick();
        checks++;
        if (acc_cnt !== 4 || tready !== 1'b0) begin
          failures++;
          $display("FAIL bp_stall got accepts=%0d tready=%b required accepts=4 tready=0", acc_cnt, tready);
        end
        checks++;
        if (pix_q.size() !== 0) begin
          failures++;
          $display("FAIL bp_idle_output got=%0d pixels required=0", pix_q.size());
        end
        enable = 1'b1;
      end
    join
    wait_done();
    repeat (8) tick();
    checks++;
    if (pix_q.size() !== 8 || acc_cnt !== 8) begin
      failures++;
      $display("FAIL bp_counts got pixels=%0d accepts=%0d required 8 8", pix_q.size(), acc_cnt);
    end
    check_frame("bp", 2, 0);
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL bp_underrun got=%b required=0", underrun);
    end
  endtask

  task automatic test_underrun();
    logic [31:0] b;
    do_reset();
    enable = 1'b1;
    send_frame(3, 5);
    wait_done();
    checks++;
    if (pix_q.size() !== 8) begin
      failures++;
      $display("FAIL underrun_pixel_count got=%0d required=8", pix_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        b = beat(3, i);
        checks++;
        if (i < 5 && (pix_q[i].rgb !== b[23:0] || pix_q[i].und !== 1'b0)) begin
          failures++;
          $display("FAIL underrun_pixel[%0d] got rgb=%h und=%b required rgb=%h und=0",
                   i, pix_q[i].rgb, pix_q[i].und, b[23:0]);
        end else if (i >= 5 && (pix_q[i].rgb !== 24'h0 || pix_q[i].und !== 1'b1)) begin
          failures++;
          $display("FAIL underrun_pixel[%0d] got rgb=%h und=%b required rgb=000000 und=1",
                   i, pix_q[i].rgb, pix_q[i].und);
        end
      end
    end
    repeat (10) tick();
    checks++;
    if (underrun !== 1'b1) begin
      failures++;
      $display("FAIL underrun_sticky got=%b required=1", underrun);
    end
  endtask

  task automatic test_reset_mid_frame();
    int g = 0;
    do_reset();
    enable = 1'b1;
    send_frame(4, 8);
    while (pix_q.size() < 5 && g < 100) begin
      tick();
      g++;
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({tready, valid, red, green, blue, sof, eol, frame_done, underrun, sync_err} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got tready=%b valid=%b rgb=%h%h%h required all 0",
               tready, valid, red, green, blue);
    end
    tick();
    tick();
    reset = 1'b1;
    pix_q.delete();
    fd_q.delete();
    send_frame(5, 8);
    wait_done();
    repeat (6) tick();
    checks++;
    if (pix_q.size() !== 8) begin
      failures++;
      $display("FAIL midreset_replay_count got=%0d required=8", pix_q.size());
    end
    check_frame("midreset", 5, 0);
  endtask

`ifdef AXIS_RGB_SYNC_CHECK_EN
  task automatic test_sync_resync();
    do_reset();
    enable = 1'b1;
    send_beat(32'h00DEAD01, 1'b0, 1'b0);
    send_beat(32'h00DEAD02, 1'b0, 1'b0);
    send_frame(6, 8);
    wait_done();
    repeat (6) tick();
    checks++;
    if (pix_q.size() !== 8 || sync_err !== 1'b0) begin
      failures++;
      $display("FAIL resync_junk got pixels=%0d sync_err=%b required 8 0", pix_q.size(), sync_err);
    end
    check_frame("resync", 6, 0);
  endtask

  task automatic test_sync_abort();
    logic [31:0] b;
    do_reset();
    enable = 1'b1;
    send_beat(beat(7, 0), 1'b1, 1'b0);
    send_beat(beat(7, 1), 1'b0, 1'b0);
    send_beat(beat(7, 2), 1'b0, 1'b1);
    send_beat(beat(7, 3), 1'b0, 1'b0);
    send_frame(8, 8);
    wait_done();
    repeat (6) tick();
    checks++;
    if (sync_err !== 1'b1) begin
      failures++;
      $display("FAIL abort_sync_err got=%b required=1", sync_err);
    end
    checks++;
    if (pix_q.size() !== 10) begin
      failures++;
      $display("FAIL abort_pixel_count got=%0d required=10", pix_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        b = beat(7, i);
        checks++;
        if (pix_q[i].rgb !== b[23:0]) begin
          failures++;
          $display("FAIL abort_pre_pixel[%0d] got=%h required=%h", i, pix_q[i].rgb, b[23:0]);
        end
      end
      checks++;
      if (pix_q[2].c - pix_q[1].c < 2) begin
        failures++;
        $display("FAIL abort_valid_drop got gap=%0d required>=2", pix_q[2].c - pix_q[1].c);
      end
      check_frame("abort", 8, 2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_back_pressure();
    test_underrun();
    test_reset_mid_frame();
`ifdef AXIS_RGB_SYNC_CHECK_EN
    test_sync_resync();
    test_sync_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
